muntjac_fpu_shift_arbiter: RTL
==============================

// Module: muntjac_fpu_shift_arbiter
//
// PURPOSE
// - Shares one sticky right-shift datapath among NumReq FPU requesters.
//   Typical requesters: adder exponent alignment, float->int conversion, denormal handling.
// - Round-robin arbitration; one request is accepted per cycle.
// - The shift result is held in a single-entry output register and returned to the owner.
// - Sits between the FPU sub-units and one shared sticky-shift instance.
//
// PARAMETERS
// - DataWidth  64  width of operand and result
// - ShiftWidth 7   width of the shift amount
// - NumReq     2   number of requesters, >=2
//
// PORTS
// - clk_i        in   1                     clock
// - rst_i        in   1                     synchronous, active-high reset
// - req_valid_i  in   NumReq                request valid, one bit per requester
// - req_ready_o  out  NumReq                request accepted (grant), one-hot or zero
// - req_data_i   in   NumReq x DataWidth    operand per requester
// - req_shift_i  in   NumReq x ShiftWidth   shift amount per requester
// - rsp_valid_o  out  NumReq                result valid, one-hot to owner, or zero
// - rsp_ready_i  in   NumReq                owner accepts result
// - rsp_data_o   out  DataWidth             result, shared bus, qualified by rsp_valid_o
//
// BEHAVIOUR
// - Reset (clk_i edge with rst_i=1):
//   - rsp_valid_o=0 and the output entry becomes empty.
//   - rsp_data_o=0; the owner id and rr pointer are cleared to 0.
//   - A held result is discarded; no response is ever issued for it.
// - Shift function, with s=req_shift_i and W=DataWidth:
//   - s>=W: r=0. Sticky is lost; this is defined behaviour.
//   - Otherwise: r = {d[W-1:1]>>s, |d[s:0]}.
//   - s=0 returns d unchanged.
// - FSM states:
//   - EMPTY: rsp_valid_o=0.
//   - FULL: rsp_valid_o[owner]=1 and rsp_data_o=held result.
// - Drain: drain = FULL & rsp_ready_i[owner]. rsp_ready_i bits of non-owners are ignored.
// - Grant:
//   - Grants are allowed only when (EMPTY | drain).
//   - Pick the first i with req_valid_i[i], searching from rr_ptr upward with wrap.
//   - Set req_ready_o[i]=1 and all other bits 0.
//   - When no grant is allowed, req_ready_o=0.
// - Grant combinational dependencies:
//   - req_ready_o may depend combinationally on req_valid_i and rsp_ready_i.
//   - rsp_valid_o must not depend combinationally on any input.
// - Accept edge (valid&ready for requester i):
//   - The entry captures r(req_data_i[i], req_shift_i[i]) and owner=i; state becomes FULL.
//   - rr_ptr becomes (i+1) mod NumReq.
// - Latency and throughput:
//   - Latency is exactly 1 cycle: the result is visible the cycle after accept.
//   - Drain and accept in the same cycle keep FULL with the new result.
//   - Back-to-back throughput is 1 per cycle.
// - Drain with no grant: state becomes EMPTY. rsp_data_o holds its last value; it is don't-care.
// - No grant edge: rr_ptr is unchanged. Requesters are starvation-free within NumReq grants.
// - Held values: a held result and its owner are stable until drained. Arbitration is skipped while FULL and not draining.
// - Requester rules:
//   - Operands must stay stable while valid is high and unaccepted.
//   - A requester may drop valid without being granted.
//
// STRUCTURE
// - muntjac_fpu_pkg: add the localparam ReqIdWidth = $clog2(NumReq) helper and the state enum (EMPTY, FULL).
// - One sub-module: muntjac_fpu_right_shift (DataWidth, ShiftWidth).
//   - It is instantiated once and fed by the granted operand mux.
//   - It is the only shift datapath; do not duplicate it per requester.
// - Local logic: round-robin picker, operand mux, output register, owner/rr_ptr registers.
//
// TESTING (DataWidth=8, ShiftWidth=4, NumReq=2)
// - Req0 d=0xB5 s=3, EMPTY -> ready0=1 same cycle; next cycle rsp_valid_o=01, rsp_data_o=0x17.
// - Req0 d=0xB5 s=0 -> 0xB5; d=0x80 s=7 -> 0x01; d=0x10 s=4 -> 0x01; d=0xFF s=8 or s=15 -> 0x00.
// - Both valid every cycle, rsp_ready_i=11 -> grants alternate 0,1,0,1 from reset; one result per cycle; owners match.
// - FULL owner 1, rsp_ready_i=01 (non-owner ready) for 5 cycles -> no drain, req_ready_o=00; result and owner stable.
// - Drain and new accept in the same cycle -> no bubble; rsp_valid_o switches to the new owner next cycle.
// - rst_i=1 while FULL -> next cycle rsp_valid_o=0; the first post-reset grant goes to req0 if both valid.

Source files
------------

// File: rtl/muntjac_fpu_pkg.sv
// Shared types and helpers for the FPU shift arbiter slice.
package muntjac_fpu_pkg;

  localparam int unsigned NumReqDefault = 2;
  localparam int unsigned ReqIdWidth    = $clog2(NumReqDefault);

  // Output entry occupancy.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned req_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/muntjac_fpu_right_shift.sv
// Sticky right shift: the shifted-out bits are ORed into the result LSB.
// An amount of DataWidth or more yields zero, discarding the sticky bit.
module muntjac_fpu_right_shift #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned ShiftWidth = 7
) (
  input  logic [DataWidth-1:0]  data,
  input  logic [ShiftWidth-1:0] shamt,
  output logic [DataWidth-1:0]  result
);

  logic [DataWidth-1:0] sticky_mask;
  logic [DataWidth-2:0] upper;

  // Shift the upper bits and fold bits [shamt:0] into the sticky LSB.
  always_comb begin
    result      = '0;
    sticky_mask = '0;
    upper       = '0;
    if (32'(shamt) < DataWidth) begin
      for (int unsigned k = 0; k < DataWidth; k++) begin
        sticky_mask[k] = (k <= 32'(shamt));
      end
      upper  = data[DataWidth-1:1] >> shamt;
      result = {upper, |(data & sticky_mask)};
    end
  end

endmodule

// File: rtl/muntjac_fpu_shift_arbiter.sv
// Round-robin arbiter sharing one sticky right shifter among NumReq
// requesters, with a single-entry registered result returned to its owner.
module muntjac_fpu_shift_arbiter
  import muntjac_fpu_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned ShiftWidth = 7,
  parameter int unsigned NumReq     = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_data_i,
  input  logic [NumReq-1:0][ShiftWidth-1:0]     req_shift_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  input  logic [NumReq-1:0]                     rsp_ready_i,
  output logic [DataWidth-1:0]                  rsp_data_o
);

  localparam int unsigned IdW = req_id_width(NumReq);

  state_e               state_q;
  logic [IdW-1:0]       owner_q;
  logic [IdW-1:0]       rr_q;
  logic [DataWidth-1:0] data_q;

  logic                 drain;
  logic                 grant_allowed;
  logic                 found;
  logic [IdW-1:0]       pick;
  int unsigned          idx;
  logic                 accept;

  logic [DataWidth-1:0]  sel_data;
  logic [ShiftWidth-1:0] sel_shift;
  logic [DataWidth-1:0]  shifted;

  // Entry empties when its owner (and only its owner) takes the result.
  assign drain         = (state_q == FULL) && rsp_ready_i[owner_q];
  assign grant_allowed = (state_q == EMPTY) || drain;

  // First valid requester at or after rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(rr_q) + k) % NumReq;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end
  end

  assign accept = grant_allowed && found;

  // One-hot grant, only when the entry can take a new result.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[pick] = 1'b1;
    end
  end

  // Operand mux feeding the single shared shifter.
  always_comb begin
    sel_data  = req_data_i[pick];
    sel_shift = req_shift_i[pick];
  end

  muntjac_fpu_right_shift #(
    .DataWidth  (DataWidth),
    .ShiftWidth (ShiftWidth)
  ) u_shift (
    .data   (sel_data),
    .shamt  (sel_shift),
    .result (shifted)
  );

  // Output entry, owner and round-robin pointer.
  // Accept takes priority over drain so a same-cycle drain+accept stays FULL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      owner_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
    end else if (accept) begin
      state_q <= FULL;
      owner_q <= pick;
      data_q  <= shifted;
      rr_q    <= (32'(pick) == NumReq - 1) ? '0 : pick + IdW'(1);
    end else if (drain) begin
      state_q <= EMPTY;
    end
  end

  // Response valid comes purely from registered state.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == FULL) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  assign rsp_data_o = data_q;

endmodule
